core_sequencer: RTL and testbench

Multi-cycle control sequencer for the single-issue RV32 core. It owns the instruction memory write port during program load and steps the datapath through fetch, decode, execute, memory and writeback, one instruction at a time. It gates the combinational control-unit enables (PC write, register write, data-memory access) so each takes effect in exactly one cycle. It sits between the top level, the instruction/data memories, the program counter, the register file and the control unit.

---
 rtl/core_pkg.sv | 21 ++
 rtl/load_addr_counter.sv | 26 ++
 rtl/core_sequencer.sv | 171 +++++++++++++++++
 tb/tb_core_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core control path: sequencer states and
// the opcodes the sequencer cares about.
package core_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_FETCH  = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_WB     = 4'd6,
        S_HALT   = 4'd7,
        S_ERROR  = 4'd8
    } seq_state_t;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

endpackage

// File: rtl/load_addr_counter.sv
// Byte address of the next instruction word to be written during program
// load; steps by one word and wraps at the top of instruction memory.
module load_addr_counter #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  clr,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ~ADDR_WIDTH'(3);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (en) begin
            addr <= (addr == LAST_WORD) ? '0 : addr + WORD_STEP;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: owns program load into instruction memory and steps
// the datapath through fetch/decode/execute/memory/writeback per instruction.
module core_sequencer
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  load_mode,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic [6:0]            opcode,
    input  logic                  cu_regwrite,
    input  logic                  cu_pc_write,
    input  logic                  cu_memread,
    input  logic                  cu_memwrite,
    input  logic                  dmem_ack,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_wr_data,
    output logic                  imem_rd_en,
    output logic                  ir_load,
    output logic                  pc_write_en,
    output logic                  pc_rst,
    output logic                  reg_write_en,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic                  busy,
    output logic                  halted,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  retired
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    seq_state_t            state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  halt_pend_q, halt_pend_d;
    logic [CNT_WIDTH-1:0]  retired_d;
    logic                  pc_rst_d;
    logic                  load_clr;
    logic                  accept;
    logic                  wb_q;
    logic                  in_exec;
    logic [ADDR_WIDTH-1:0] load_addr;

    assign accept = ld_ready & ld_valid;
    assign in_exec = (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});

    // Memory/writeback strobes follow the control unit only in their own cycle.
    assign dmem_we      = dmem_req & cu_memwrite;
    assign reg_write_en = wb_q & cu_regwrite;
    assign pc_write_en  = wb_q & cu_pc_write;

    load_addr_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_load_addr (
        .clk   (clk),
        .arst_n(arst_n),
        .clr   (load_clr),
        .en    (accept),
        .addr  (load_addr)
    );

    // Next-state, wait counter, pending halt and retire count.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        retired_d   = retired;
        pc_rst_d    = 1'b0;
        load_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_mode) begin
                    state_d  = S_LOAD;
                    load_clr = 1'b1;
                end else if (start) begin
                    state_d   = S_FETCH;
                    pc_rst_d  = 1'b1;
                    retired_d = '0;
                end
            end
            S_LOAD: begin
                if (!load_mode) begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (opcode == OPC_SYSTEM) ? S_HALT : S_EXEC;
            S_EXEC: begin
                wait_d  = '0;
                state_d = (cu_memread || cu_memwrite) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                retired_d = (&retired) ? retired : retired + CNT_WIDTH'(1);
                state_d   = (halt_req || halt_pend_q) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (load_mode) begin
                    state_d  = S_LOAD;
                    load_clr = 1'b1;
                end else if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
        // A halt request seen mid-instruction is held until the boundary.
        halt_pend_d = (halt_pend_q || (halt_req && in_exec)) && (state_d != S_HALT);
    end

    // State register; every non-gated output is registered off the next state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            halt_pend_q  <= 1'b0;
            retired      <= '0;
            ld_ready     <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            imem_rd_en   <= 1'b0;
            ir_load      <= 1'b0;
            pc_rst       <= 1'b0;
            dmem_req     <= 1'b0;
            wb_q         <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            halt_pend_q <= halt_pend_d;
            retired     <= retired_d;
            ld_ready    <= (state_d == S_LOAD);
            imem_wr_en  <= accept;
            if (accept) begin
                imem_wr_addr <= load_addr;
                imem_wr_data <= ld_data;
            end
            imem_rd_en <= (state_d == S_FETCH);
            ir_load    <= (state_d == S_DECODE);
            pc_rst     <= pc_rst_d;
            dmem_req   <= (state_d == S_MEM);
            wb_q       <= (state_d == S_WB);
            busy       <= !(state_d inside {S_IDLE, S_HALT, S_ERROR});
            halted     <= (state_d == S_HALT);
            error      <= (state_d == S_ERROR);
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer: instruction timelines and
// load transfers are predicted from per-instruction cycle budgets and word indices.
module tb_core_sequencer;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 10;
    localparam int unsigned TO      = 15;
    localparam int unsigned CW      = 4;
    localparam int unsigned RET_MAX = (1 << CW) - 1;
    localparam logic [6:0]  EBREAK_OPC = 7'b1110011;

    logic          clk;
    logic          arst_n;
    logic          load_mode;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          start;
    logic          halt_req;
    logic [6:0]    opcode;
    logic          cu_regwrite;
    logic          cu_pc_write;
    logic          cu_memread;
    logic          cu_memwrite;
    logic          dmem_ack;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [DW-1:0] imem_wr_data;
    logic          imem_rd_en;
    logic          ir_load;
    logic          pc_write_en;
    logic          pc_rst;
    logic          reg_write_en;
    logic          dmem_req;
    logic          dmem_we;
    logic          busy;
    logic          halted;
    logic          error;
    logic [CW-1:0] retired;

    int          n_tests;
    int          n_fail;
    int unsigned model_ret;
    bit          exp_prst;
    bit          is_halted;
    logic [DW-1:0] prog [3];

    core_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .load_mode   (load_mode),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .start       (start),
        .halt_req    (halt_req),
        .opcode      (opcode),
        .cu_regwrite (cu_regwrite),
        .cu_pc_write (cu_pc_write),
        .cu_memread  (cu_memread),
        .cu_memwrite (cu_memwrite),
        .dmem_ack    (dmem_ack),
        .imem_wr_en  (imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .imem_rd_en  (imem_rd_en),
        .ir_load     (ir_load),
        .pc_write_en (pc_write_en),
        .pc_rst      (pc_rst),
        .reg_write_en(reg_write_en),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .busy        (busy),
        .halted      (halted),
        .error       (error),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ld_ready"}, 64'(ld_ready), 64'(0));
        check({tag, "_wr_en"}, 64'(imem_wr_en), 64'(0));
        check({tag, "_wr_addr"}, 64'(imem_wr_addr), 64'(0));
        check({tag, "_wr_data"}, 64'(imem_wr_data), 64'(0));
        check({tag, "_rd_en"}, 64'(imem_rd_en), 64'(0));
        check({tag, "_ir_load"}, 64'(ir_load), 64'(0));
        check({tag, "_pc_we"}, 64'(pc_write_en), 64'(0));
        check({tag, "_pc_rst"}, 64'(pc_rst), 64'(0));
        check({tag, "_reg_we"}, 64'(reg_write_en), 64'(0));
        check({tag, "_dmem_req"}, 64'(dmem_req), 64'(0));
        check({tag, "_dmem_we"}, 64'(dmem_we), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_halted"}, 64'(halted), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
        check({tag, "_retired"}, 64'(retired), 64'(0));
    endtask

    // Load n words; word i must appear on the write port one cycle after acceptance at byte address 4*i mod 2^AW.
    task automatic load_prog(input int unsigned n, input bit gaps, input bit use_prog, input bit enter);
        int unsigned   sent;
        bit            acc_prev;
        bit            v;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] w;
        sent = 0;
        acc_prev = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        start = 1'b0;
        if (enter) begin
            load_mode = 1'b1;
            #1;
            step();
        end
        while (sent < n) begin
            #1;
            check("ld_wr_en", 64'(imem_wr_en), 64'(acc_prev));
            if (acc_prev) begin
                check("ld_wr_addr", 64'(imem_wr_addr), 64'(prev_addr));
                check("ld_wr_data", 64'(imem_wr_data), 64'(prev_data));
            end
            check("ld_ready", 64'(ld_ready), 64'(1));
            v = gaps ? 1'($urandom % 2) : 1'b1;
            w = (use_prog && sent < 3) ? prog[sent] : DW'($urandom);
            ld_valid = v;
            ld_data  = w;
            acc_prev = v;
            if (v) begin
                prev_addr = AW'((sent * 4) % (1 << AW));
                prev_data = w;
                sent++;
                if (sent == n) load_mode = 1'b0;
            end
            step();
        end
        ld_valid = 1'b0;
        #1;
        check("ld_last_wr_en", 64'(imem_wr_en), 64'(1));
        check("ld_last_addr", 64'(imem_wr_addr), 64'(prev_addr));
        check("ld_last_data", 64'(imem_wr_data), 64'(prev_data));
        check("ld_exit_ready", 64'(ld_ready), 64'(0));
        check("ld_exit_busy", 64'(busy), 64'(0));
        step();
        #1;
        check("ld_after_wr_en", 64'(imem_wr_en), 64'(0));
    endtask

    task automatic do_start(input bit from_idle);
        start = 1'b1;
        #1;
        step();
        start = 1'b0;
        if (from_idle) model_ret = 0;
        exp_prst = from_idle;
        is_halted = 1'b0;
    endtask

    // One instruction from its FETCH cycle: 4 cycles, or 5+n with a memory phase of n+1 cycles.
    task automatic exec_instr(input bit mem, input int unsigned n, input bit regw,
                              input bit pcw, input bit mw, input bit hreq);
        int unsigned len;
        bit          in_mem;
        bit          in_wb;
        logic [6:0]  opc;
        len = mem ? 5 + n : 4;
        do opc = 7'($urandom); while (opc == EBREAK_OPC);
        for (int unsigned k = 0; k < len; k++) begin
            in_mem = mem && (k >= 3) && (k <= 3 + n);
            in_wb  = (k == len - 1);
            opcode      = opc;
            cu_regwrite = regw;
            cu_pc_write = pcw;
            cu_memread  = mem && !mw;
            cu_memwrite = mem && mw;
            dmem_ack    = in_mem ? (k == 3 + n) : 1'($urandom % 2);
            halt_req    = hreq && (k == 2);
            #1;
            if (k == 0) begin
                check("ex_pc_rst", 64'(pc_rst), 64'(exp_prst));
                check("ex_ret_start", 64'(retired), 64'(model_ret));
            end else begin
                check("ex_pc_rst_low", 64'(pc_rst), 64'(0));
            end
            check("ex_rd_en", 64'(imem_rd_en), 64'(k == 0));
            check("ex_ir_load", 64'(ir_load), 64'(k == 1));
            check("ex_dmem_req", 64'(dmem_req), 64'(in_mem));
            check("ex_dmem_we", 64'(dmem_we), 64'(in_mem && mw));
            check("ex_reg_we", 64'(reg_write_en), 64'(in_wb && regw));
            check("ex_pc_we", 64'(pc_write_en), 64'(in_wb && pcw));
            check("ex_busy", 64'(busy), 64'(1));
            step();
        end
        exp_prst = 1'b0;
        halt_req = 1'b0;
        dmem_ack = 1'b0;
        if (model_ret < RET_MAX) model_ret++;
        #1;
        check("ex_retired", 64'(retired), 64'(model_ret));
        if (hreq) begin
            check("ex_halted", 64'(halted), 64'(1));
            check("ex_halt_rd", 64'(imem_rd_en), 64'(0));
            step();
            #1;
            check("ex_halt_stay_rd", 64'(imem_rd_en), 64'(0));
            check("ex_halt_stay", 64'(halted), 64'(1));
            is_halted = 1'b1;
        end else begin
            check("ex_next_fetch", 64'(imem_rd_en), 64'(1));
        end
    endtask

    task automatic exec_ebreak();
        opcode = 7'h33;
        cu_regwrite = 1'b1;
        cu_pc_write = 1'b1;
        cu_memread  = 1'b0;
        cu_memwrite = 1'b0;
        #1;
        check("eb_rd_en", 64'(imem_rd_en), 64'(1));
        check("eb_pc_rst", 64'(pc_rst), 64'(exp_prst));
        exp_prst = 1'b0;
        step();
        opcode = EBREAK_OPC;
        #1;
        check("eb_ir_load", 64'(ir_load), 64'(1));
        check("eb_reg_we", 64'(reg_write_en), 64'(0));
        step();
        #1;
        check("eb_halted", 64'(halted), 64'(1));
        check("eb_busy", 64'(busy), 64'(0));
        check("eb_rd_en_off", 64'(imem_rd_en), 64'(0));
        check("eb_pc_we", 64'(pc_write_en), 64'(0));
        check("eb_retired", 64'(retired), 64'(model_ret));
        is_halted = 1'b1;
    endtask

    // Memory access with the ack withheld: TO request cycles, then sticky error.
    task automatic timeout_case();
        opcode      = 7'h03;
        cu_regwrite = 1'b1;
        cu_pc_write = 1'b0;
        cu_memread  = 1'b1;
        cu_memwrite = 1'b0;
        dmem_ack    = 1'b0;
        for (int unsigned k = 0; k < 3 + TO; k++) begin
            #1;
            check("to_dmem_req", 64'(dmem_req), 64'(k >= 3));
            check("to_error_low", 64'(error), 64'(0));
            check("to_busy", 64'(busy), 64'(1));
            step();
        end
        exp_prst = 1'b0;
        #1;
        check("to_error", 64'(error), 64'(1));
        check("to_busy_off", 64'(busy), 64'(0));
        check("to_req_off", 64'(dmem_req), 64'(0));
        check("to_reg_we", 64'(reg_write_en), 64'(0));
        for (int k = 0; k < 6; k++) begin
            start     = 1'($urandom % 2);
            load_mode = 1'($urandom % 2);
            dmem_ack  = 1'($urandom % 2);
            #1;
            step();
            #1;
            check("to_sticky", 64'(error), 64'(1));
            check("to_sticky_ready", 64'(ld_ready), 64'(0));
            check("to_sticky_rd", 64'(imem_rd_en), 64'(0));
        end
        start     = 1'b0;
        load_mode = 1'b0;
        dmem_ack  = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        model_ret = 0;
        exp_prst  = 1'b0;
        is_halted = 1'b0;
        prog[0] = 32'h00500093;
        prog[1] = 32'h00108133;
        prog[2] = 32'h00100073;

        arst_n      = 1'b0;
        load_mode   = 1'b1;
        ld_valid    = 1'b0;
        ld_data     = '0;
        start       = 1'b0;
        halt_req    = 1'b0;
        opcode      = '0;
        cu_regwrite = 1'b1;
        cu_pc_write = 1'b1;
        cu_memread  = 1'b1;
        cu_memwrite = 1'b1;
        dmem_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        cu_regwrite = 1'b0;
        cu_pc_write = 1'b0;
        cu_memread  = 1'b0;
        cu_memwrite = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        step();
        check("rel_ld_ready", 64'(ld_ready), 64'(1));
        check("rel_busy", 64'(busy), 64'(1));

        load_prog(3, 1'b0, 1'b1, 1'b0);

        do_start(1'b1);
        exec_instr(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        exec_instr(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ret_two", 64'(retired), 64'(2));
        exec_ebreak();
        do_start(1'b0);

        exec_instr(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        exec_instr(1'b1, $urandom_range(0, TO - 1), 1'b0, 1'b0, 1'b1, 1'b0);
        exec_instr(1'b1, TO - 1, 1'b1, 1'b1, 1'b0, 1'b0);
        exec_instr(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);

        load_prog(258, 1'b0, 1'b0, 1'b1);
        do_start(1'b1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                exec_ebreak();
            end else begin
                exec_instr(1'($urandom % 2), $urandom_range(0, TO - 1), 1'($urandom % 2),
                           1'($urandom % 2), 1'($urandom % 2), $urandom_range(0, 7) == 0);
            end
            if (is_halted) begin
                if ($urandom_range(0, 2) == 0) begin
                    load_prog($urandom_range(1, 6), 1'b1, 1'b0, 1'b1);
                    do_start(1'b1);
                end else begin
                    do_start(1'b0);
                end
            end
        end

        timeout_case();

        cu_regwrite = 1'b1;
        cu_pc_write = 1'b1;
        cu_memread  = 1'b1;
        cu_memwrite = 1'b1;
        arst_n = 1'b0;
        #1;
        check_zero("rst_err");
        @(negedge clk);
        arst_n      = 1'b1;
        cu_regwrite = 1'b0;
        cu_pc_write = 1'b0;
        cu_memread  = 1'b0;
        cu_memwrite = 1'b0;
        step();
        #1;
        check("post_err_busy", 64'(busy), 64'(0));
        check("post_err_error", 64'(error), 64'(0));

        do_start(1'b1);
        opcode      = 7'h13;
        cu_regwrite = 1'b1;
        cu_pc_write = 1'b1;
        repeat (3) step();
        #1;
        check("mid_wb_reg_we", 64'(reg_write_en), 64'(1));
        check("mid_wb_pc_we", 64'(pc_write_en), 64'(1));
        arst_n = 1'b0;
        #1;
        check_zero("rst_wb");
        @(negedge clk);
        arst_n = 1'b1;
        step();
        #1;
        check("post_wb_reg_we", 64'(reg_write_en), 64'(0));
        check("post_wb_busy", 64'(busy), 64'(0));
        check("post_wb_retired", 64'(retired), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
